mux2_rr_arbiter: RTL
====================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 2:1 mux output path between requesters A and B.
//  - Each requester offers packets of WIDTH-bit beats over valid/ready with a last flag.
//  - A grant is held for a whole packet; the select line steers the mux.
//  - The output goes through one register stage to the downstream consumer.
// PARAMETERS
//  WIDTH      8  data width of each beat
//  INIT_PRIO  0  requester favoured first after reset: 0 = A, 1 = B
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  a_valid    in   1      A presents a beat
//  a_data     in   WIDTH  A beat data
//  a_last     in   1      A beat is the final beat of its packet
//  a_ready    out  1      A beat accepted this cycle when a_valid is also high
//  b_valid    in   1      B presents a beat
//  b_data     in   WIDTH  B beat data
//  b_last     in   1      B beat is the final beat of its packet
//  b_ready    out  1      B beat accepted this cycle when b_valid is also high
//  y_valid    out  1      registered output beat valid
//  y_data     out  WIDTH  registered output data
//  y_last     out  1      registered output last flag
//  y_ready    in   1      downstream accepts y when y_valid is also high
//  select     out  1      current grant: 0 = A, 1 = B; drives the mux select
//  busy       out  1      high while a packet grant is held (GRANT state)
// BEHAVIOUR
//  Reset: all outputs 0, except select = INIT_PRIO; state = IDLE; rr_ptr = INIT_PRIO.
//   - A reset mid-packet discards the packet and any y beat held in the register.
//  State IDLE:
//   - No request: stay in IDLE.
//   - Exactly one valid: grant that requester.
//   - Both valid: grant the requester named by rr_ptr.
//   - On a grant: select <= granted requester; next state GRANT; busy <= 1.
//   - a_ready = b_ready = 0 throughout IDLE (one-cycle arbitration bubble).
//  State GRANT:
//   - Only the granted requester's ready may be high.
//   - That ready = !y_valid || y_ready (single register with pass-through refill).
//   - The ungranted ready is held at 0.
//   - An accepted beat is loaded into y_data/y_last with y_valid <= 1.
//     Latency is 1 cycle from input accept to y_valid.
//   - Accepting a beat with last = 1: next state IDLE; busy <= 0;
//     rr_ptr <= !select so the other requester wins the next tie.
//   - A granted requester that drops valid mid-packet keeps the grant; no timeout.
//  Output register: y_valid clears when y_ready = 1 and no new beat is accepted that cycle.
//   - y_data is stable while y_valid && !y_ready.
//   - A simultaneous y drain and input accept in the same cycle: the register is
//     refilled and y_valid stays 1.
//  select changes only on the IDLE-to-GRANT transition.
//  Throughput: one beat per cycle sustained within a packet while y_ready = 1.
//   - Each packet costs exactly one IDLE bubble cycle.
//  Single-beat packets (last on the first beat) are legal: GRANT lasts one cycle
//   when y has room.
// CONFIGURATION
//  MUX2_ARB_PERF_EN defined:
//   - Adds outputs pkt_cnt_a and pkt_cnt_b, each 16 bits.
//   - Each counts packets completed (last beat accepted) per requester.
//   - Counters wrap 0xFFFF -> 0 and reset to 0.
//  MUX2_ARB_PERF_EN undefined: the ports and counters are absent; all other
//   behaviour is identical.
// TESTING
//  1. Reset check: rst = 1 with random inputs -> every output 0,
//     select = INIT_PRIO, busy = 0, ready signals 0.
//  2. A alone sends 3 beats (0x11, 0x22, 0x33, last on 0x33) with y_ready = 1:
//     - Grant in cycle 1; beats accepted in cycles 2-4.
//     - y shows 0x11/0x22/0x33 in cycles 3-5, with y_last on 0x33.
//     - select = 0 throughout.
//  3. A and B both request continuously with 2-beat packets, INIT_PRIO = 0:
//     - Grant order is A, B, A, B.
//     - The output alternates packets with no beat interleaving.
//  4. Backpressure: y_ready = 0 for 4 cycles during A packet 0xAA, 0xBB:
//     - y_data holds 0xAA; a_ready = 0 after the register fills.
//     - After y_ready rises, 0xBB follows with no loss or duplication.
//  5. Reset mid-packet: rst pulses after beat 1 of a 3-beat B packet:
//     - y_valid = 0 immediately (asynchronous); state returns to IDLE.
//     - The next request is arbitrated fresh from INIT_PRIO.
//  6. With MUX2_ARB_PERF_EN: 3 A packets and 2 B packets -> pkt_cnt_a = 3, pkt_cnt_b = 2.
//     - Preload pkt_cnt_a to 0xFFFF via force, then complete one A packet -> pkt_cnt_a = 0.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter steering one of two valid/ready packet sources onto a registered 2:1 mux output.
// Optional packet counters are enabled with `define MUX2_ARB_PERF_EN.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             select,
  output logic             busy
`ifdef MUX2_ARB_PERF_EN
  ,
  output logic [15:0]      pkt_cnt_a,
  output logic [15:0]      pkt_cnt_b
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             room;
  logic             a_acc;
  logic             b_acc;
  logic             acc;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  // The output register can take a new beat when empty or when it drains this cycle.
  assign room     = !y_valid || y_ready;
  assign a_ready  = (state == GRANT) && !select && room;
  assign b_ready  = (state == GRANT) &&  select && room;
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;
  assign acc      = a_acc || b_acc;
  assign mux_data = select ? b_data : a_data;
  assign mux_last = select ? b_last : a_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      select  <= INIT_PRIO;
      rr_ptr  <= INIT_PRIO;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else begin
      if (acc) begin
        y_valid <= 1'b1;
        y_data  <= mux_data;
        y_last  <= mux_last;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (a_valid || b_valid) begin
            select <= (a_valid && b_valid) ? rr_ptr : b_valid;
            state  <= GRANT;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          // The requester that just finished loses the next tie.
          if (acc && mux_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= !select;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX2_ARB_PERF_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_acc && a_last) cnt_a <= cnt_a + 16'd1;
      if (b_acc && b_last) cnt_b <= cnt_b + 16'd1;
    end
  end

  assign pkt_cnt_a = cnt_a;
  assign pkt_cnt_b = cnt_b;
`endif

endmodule
